alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised execute-stage ALU that extends the single-cycle integer ALU with an iterative RV32M multiply/divide unit. Base operations (add through and) complete combinationally. M-extension operations are launched with a Start pulse and take a fixed number of cycles. Busy tells the hazard unit to stall the pipeline, and Done marks the cycle in which the result is valid.

## Interface
- DATA_WIDTH, 32, operand/result width (even, ≥8)
- ALU_CTRL_WIDTH, 5, control width; bit 4 selects the M-extension group
- SHIFT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from SrcB
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- SrcA  in  DATA_WIDTH  operand A (rs1)
- SrcB  in  DATA_WIDTH  operand B (rs2/imm)
- ALUControl  in  ALU_CTRL_WIDTH  operation select
- Start  in  1  launch an M op; sampled only when ALUControl[4]=1
- ALUResult  out  DATA_WIDTH  result
- Zero  out  1  ALUResult == 0
- Busy  out  1  M op in flight; pipeline must stall
- Done  out  1  one-cycle pulse, M result valid on ALUResult

## Operation
- Base group (ALUControl[4]=0), combinational, same cycle:
  - 00000 add; 00001 sub; 00010 sll; 00011 slt (signed); 00100 sltu
  - 00101 xor; 00110 srl; 00111 sra; 01000 or; 01001 and
  - all other 0xxxx codes default to add
  - shift amount = SrcB[SHIFT_WIDTH-1:0]
  - slt is a true signed compare, correct for all sign combinations
  - slt/sltu return 1 or 0, zero-extended to DATA_WIDTH
- M group (ALUControl[4]=1):
  - 10000 mul (low half); 10001 mulh (s×s high); 10010 mulhsu (s×u high); 10011 mulhu (u×u high)
  - 10100 div; 10101 divu; 10110 rem; 10111 remu
  - 11xxx codes behave as mul
- ALUResult mux:
  - ALUControl[4]=0: combinational base result
  - ALUControl[4]=1: registered M result (holds its last value; reset 0)
- Zero is always derived from the muxed ALUResult.
- Datapath, radix-2 iterative:
  - operands are converted to magnitudes per signedness and the result signs are recorded at capture
  - multiply: shift-add into a 2×DATA_WIDTH accumulator
  - divide: restoring shift-subtract producing quotient and remainder
- Sign rules:
  - quotient is negated if the operand signs differ
  - remainder takes the dividend's sign
- Special cases, flagged at capture:
  - divide by zero: quotient all-ones, remainder = SrcA
  - signed overflow (most-negative ÷ −1): quotient = most-negative, remainder 0
  - special cases do not shorten latency
- FSM states: IDLE, CALC, FIXUP, DONE.
  - IDLE → CALC on Start & ALUControl[4]: operands, opcode and flags are captured and the counter is loaded with DATA_WIDTH
  - CALC → FIXUP when the counter reaches 0 (one step per cycle)
  - FIXUP → DONE: sign correction, half select, special-case override; result register written
  - DONE → IDLE, or DONE → CALC if a new Start is present (back-to-back launch)
- Start while in CALC/FIXUP is ignored.
- Operands may change after capture without effect.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, result register 0, counter 0.
- Reset mid-operation aborts immediately. No Done is produced for the aborted op.
- Start sampled at edge 0 → Busy=1 from cycle 1 to cycle DATA_WIDTH+1 inclusive.
- Done=1 and result valid in cycle DATA_WIDTH+2, where Busy=0. Latency is 34 cycles at DATA_WIDTH=32.
- Busy and Done are registered (state decodes). There is no combinational path from Start to Busy.
- Base ops issued while the unit is idle or in DONE never stall.

## Structure
- Shared package alu_pkg:
  - typedef alu_op_e holding all 5-bit encodings
  - constant M_GROUP_BIT = 4
  - state enum muldiv_state_e
- Sub-module muldiv_iter holds the FSM, counter, accumulator, sign/fixup logic and result register.
- alu_muldiv holds the base combinational ALU, the result mux and Zero.

## Test plan
- Base ops, DATA_WIDTH=32:
  - slt 0xFFFFFFFF, 0x00000001 → 1
  - sltu same operands → 0
  - sra 0x80000000 by 4 → 0xF8000000
  - sub 5,5 → 0, Zero=1, Busy stays 0
- mul 0xFFFFFFFF×0xFFFFFFFF: mul → 0x00000001, mulh → 0x00000000, mulhu → 0xFFFFFFFE, mulhsu → 0xFFFFFFFF. Done exactly 34 cycles after Start.
- div −7 ÷ 2 → 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 7 ÷ 2 → 3; remu → 1.
- Special cases:
  - div 5 ÷ 0 → 0xFFFFFFFF; rem 5 ÷ 0 → 5
  - div 0x80000000 ÷ 0xFFFFFFFF → 0x80000000, rem → 0
  - latency still 34 cycles
- Start re-pulsed during CALC is ignored (one Done only). Start held in the DONE cycle launches a second op whose Done arrives 34 cycles later.
- rst asserted at cycle 10 of a div → Busy, Done and ALUResult go to 0 asynchronously. No Done follows. A fresh mul 3×4 after release → 12.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, M-unit function codes and FSM states
package alu_pkg;

  localparam int M_GROUP_BIT = 4;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_SLL    = 5'b00010,
    OP_SLT    = 5'b00011,
    OP_SLTU   = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_OR     = 5'b01000,
    OP_AND    = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  // Low three bits of an M opcode, as seen by the iterative unit
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } muldiv_state_e;

  // 11xxx codes alias to plain mul
  function automatic logic [2:0] md_func(input logic [4:0] ctrl);
    return ctrl[3] ? MD_MUL : ctrl[2:0];
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand/control/result bundle between pipeline and execute ALU
interface alu_muldiv_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 5
) ();

  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl;
  logic                      Start;
  logic [DATA_WIDTH-1:0]     ALUResult;
  logic                      Zero;
  logic                      Busy;
  logic                      Done;

  modport master (
    output SrcA, SrcB, ALUControl, Start,
    input  ALUResult, Zero, Busy, Done
  );

  modport slave (
    input  SrcA, SrcB, ALUControl, Start,
    output ALUResult, Zero, Busy, Done
  );

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 iterative multiply/divide unit with sign fixup
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            func,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e state, state_nx;
  logic          capture;

  logic [CW-1:0] cnt;
  logic [2:0]    func_q;
  logic [W-1:0]  opnd_q;      // multiplicand or divisor magnitude
  logic [W-1:0]  hi_q;        // product high half / partial remainder
  logic [W-1:0]  lo_q;        // multiplier->product low half / dividend->quotient
  logic [W-1:0]  dividend_q;  // raw SrcA, returned as remainder on divide by zero
  logic          neg_q;       // product/quotient must be negated
  logic          neg_rem_q;   // remainder takes the dividend's sign
  logic          dz_q;
  logic          ovf_q;

  logic          is_div;
  logic          signed_a;
  logic          signed_b;
  logic          sa;
  logic          sb;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;

  assign is_div   = func[2];
  assign signed_a = (func == MD_MULH) || (func == MD_MULHSU) ||
                    (func == MD_DIV)  || (func == MD_REM);
  assign signed_b = (func == MD_MULH) || (func == MD_DIV) || (func == MD_REM);
  assign sa       = signed_a & src_a[W-1];
  assign sb       = signed_b & src_b[W-1];
  assign mag_a    = sa ? (~src_a + 1'b1) : src_a;
  assign mag_b    = sb ? (~src_b + 1'b1) : src_b;

  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   fix_res;

  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign trial   = {hi_q, lo_q[W-1]} - {1'b0, opnd_q};
  assign prod_s  = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
  assign quo_s   = neg_q ? (~lo_q + 1'b1) : lo_q;
  assign rem_s   = neg_rem_q ? (~hi_q + 1'b1) : hi_q;

  // Final result selection: half select, sign correction, special-case override
  always_comb begin
    fix_res = prod_s[W-1:0];
    case (func_q)
      MD_MUL:                       fix_res = prod_s[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*W-1:W];
      MD_DIV, MD_DIVU: begin
        if (dz_q)       fix_res = {W{1'b1}};
        else if (ovf_q) fix_res = MOST_NEG;
        else            fix_res = quo_s;
      end
      default: begin
        if (dz_q)       fix_res = dividend_q;
        else if (ovf_q) fix_res = {W{1'b0}};
        else            fix_res = rem_s;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; launches are accepted only from IDLE or DONE
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_ONE) state_nx = FIXUP;
      end
      FIXUP: state_nx = DONE;
      DONE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIXUP);
  assign done = (state == DONE);

  // Operand capture, one shift-add / shift-subtract step per CALC cycle, result write in FIXUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      func_q     <= MD_MUL;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      result     <= '0;
    end else if (capture) begin
      cnt        <= CNT_LOAD;
      func_q     <= func;
      opnd_q     <= is_div ? mag_b : mag_a;
      hi_q       <= '0;
      lo_q       <= is_div ? mag_a : mag_b;
      dividend_q <= src_a;
      neg_q      <= sa ^ sb;
      neg_rem_q  <= sa;
      dz_q       <= is_div && (src_b == '0);
      ovf_q      <= is_div && signed_a && (src_a == MOST_NEG) && (src_b == {W{1'b1}});
    end else if (state == CALC) begin
      cnt <= cnt - CNT_ONE;
      if (func_q[2]) begin
        if (!trial[W]) begin
          hi_q <= trial[W-1:0];
          lo_q <= {lo_q[W-2:0], 1'b1};
        end else begin
          hi_q <= {hi_q[W-2:0], lo_q[W-1]};
          lo_q <= {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[W:1];
        lo_q <= {add_sum[0], lo_q[W-1:1]};
      end
    end else if (state == FIXUP) begin
      result <= fix_res;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - execute-stage ALU: combinational base ops plus iterative M unit
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 5,
  parameter int SHIFT_WIDTH    = $clog2(DATA_WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  alu_muldiv_if.slave bus
);

  logic [4:0]             op;
  logic                   m_group;
  logic [SHIFT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  base_res;
  logic [DATA_WIDTH-1:0]  m_res;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   m_busy;
  logic                   m_done;

  assign op      = bus.ALUControl[4:0];
  assign m_group = bus.ALUControl[M_GROUP_BIT];
  assign shamt   = bus.SrcB[SHIFT_WIDTH-1:0];

  // Single-cycle base group; unlisted codes fall back to add
  always_comb begin
    base_res = bus.SrcA + bus.SrcB;
    case (op)
      OP_ADD:  base_res = bus.SrcA + bus.SrcB;
      OP_SUB:  base_res = bus.SrcA - bus.SrcB;
      OP_SLL:  base_res = bus.SrcA << shamt;
      OP_SLT:  base_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      OP_SLTU: base_res = {{(DATA_WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_XOR:  base_res = bus.SrcA ^ bus.SrcB;
      OP_SRL:  base_res = bus.SrcA >> shamt;
      OP_SRA:  base_res = $signed(bus.SrcA) >>> shamt;
      OP_OR:   base_res = bus.SrcA | bus.SrcB;
      OP_AND:  base_res = bus.SrcA & bus.SrcB;
      default: base_res = bus.SrcA + bus.SrcB;
    endcase
  end

  muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.Start & m_group),
    .func   (md_func(op)),
    .src_a  (bus.SrcA),
    .src_b  (bus.SrcB),
    .result (m_res),
    .busy   (m_busy),
    .done   (m_done)
  );

  assign alu_res       = m_group ? m_res : base_res;
  assign bus.ALUResult = alu_res;
  assign bus.Zero      = (alu_res == '0);
  assign bus.Busy      = m_busy;
  assign bus.Done      = m_done;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv
module tb_alu_muldiv;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  alu_muldiv_if #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(5)) bus ();

  alu_muldiv #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic base_op(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.Start      = 1'b0;
    #1;
    check_vec(tag, bus.ALUResult, exp);
  endtask

  // Called one step after the launch edge (cycle 1); returns in the Done cycle
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.Done) begin
        lat = i;
        break;
      end
      if (bus.Busy) busy_n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_m(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int busy_n;
    @(posedge clk);
    #1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.SrcA  = $urandom;
    bus.SrcB  = $urandom;
    wait_done(lat, busy_n);
    check_vec({tag, "_res"}, bus.ALUResult, exp);
    check_vec({tag, "_lat"}, lat, 34);
    check_vec({tag, "_busycyc"}, busy_n, 33);
    check_vec({tag, "_busy_at_done"}, {31'b0, bus.Busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int busy_n;
    int n_done;
    int first;
    logic [31:0] first_res;

    rst            = 1'b1;
    bus.Start      = 1'b0;
    bus.ALUControl = 5'b10000;
    bus.SrcA       = 32'h0000_0000;
    bus.SrcB       = 32'h0000_0000;
    #1;
    check_vec("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check_vec("rst_done", {31'b0, bus.Done}, 32'd0);
    check_vec("rst_result", bus.ALUResult, 32'd0);
    check_vec("rst_zero", {31'b0, bus.Zero}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    base_op("slt_neg_pos", 5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    base_op("sltu_big_one", 5'b00100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    base_op("slt_pos_neg", 5'b00011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    base_op("sra_neg4", 5'b00111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    base_op("srl_4", 5'b00110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    base_op("sll_amt_wrap", 5'b00010, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
    base_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    base_op("xor", 5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    base_op("or", 5'b01000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    base_op("and", 5'b01001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    base_op("undef_is_add", 5'b01111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005);
    base_op("sub_eq", 5'b00001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    check_vec("sub_eq_zero", {31'b0, bus.Zero}, 32'd1);
    check_vec("sub_eq_busy", {31'b0, bus.Busy}, 32'd0);

    run_m("mul_m1m1", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_m("mulh_m1m1", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_m("mulhu_m1m1", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_m("mulhsu_m1m1", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_m("mul_shift", 5'b10000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    run_m("mulhu_shift", 5'b10011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001);
    run_m("mul_alias11", 5'b11000, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C);
    run_m("div_m7_2", 5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run_m("rem_m7_2", 5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run_m("divu_7_2", 5'b10101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003);
    run_m("remu_7_2", 5'b10111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001);
    run_m("div_100_m7", 5'b10100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_m("rem_100_m7", 5'b10110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002);
    run_m("div_by0", 5'b10100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    run_m("rem_by0", 5'b10110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    run_m("divu_by0", 5'b10101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    run_m("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_m("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Start re-pulsed during CALC must be ignored
    @(posedge clk);
    #1;
    bus.ALUControl = 5'b10101;
    bus.SrcA       = 32'd100;
    bus.SrcB       = 32'd7;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    n_done    = 0;
    first     = 0;
    first_res = 32'h0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 5) bus.Start = 1'b1;
      if (i == 6) bus.Start = 1'b0;
      if (bus.Done) begin
        n_done++;
        if (first == 0) begin
          first     = i;
          first_res = bus.ALUResult;
        end
      end
      @(posedge clk);
      #1;
    end
    check_vec("repulse_ndone", n_done, 1);
    check_vec("repulse_lat", first, 34);
    check_vec("repulse_res", first_res, 32'd14);

    // Start held in the DONE cycle launches the next op back to back
    run_m("b2b_first", 5'b10000, 32'd6, 32'd7, 32'd42);
    bus.ALUControl = 5'b10111;
    bus.SrcA       = 32'd100;
    bus.SrcB       = 32'd7;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    check_vec("b2b_busy_c1", {31'b0, bus.Busy}, 32'd1);
    wait_done(lat, busy_n);
    check_vec("b2b_second_lat", lat, 34);
    check_vec("b2b_second_res", bus.ALUResult, 32'd2);

    // Reset in cycle 10 of a divide aborts it
    @(posedge clk);
    #1;
    bus.ALUControl = 5'b10100;
    bus.SrcA       = 32'd1000;
    bus.SrcB       = 32'd3;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check_vec("abort_busy_before", {31'b0, bus.Busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_vec("abort_busy", {31'b0, bus.Busy}, 32'd0);
    check_vec("abort_done", {31'b0, bus.Done}, 32'd0);
    check_vec("abort_result", bus.ALUResult, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) n_done++;
    end
    check_vec("abort_no_done", n_done, 0);
    run_m("post_rst_mul", 5'b10000, 32'd3, 32'd4, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
